// File: rtl/keypad_pkg.sv
// Shared constants, FSM state encoding and key-index helper for the keypad scanner.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int KEY_W    = 16;

  typedef enum logic [0:0] {
    S_DRIVE = 1'b0,
    S_EVAL  = 1'b1
  } state_t;

  // Flat key index used by the one-hot vector: row*NUM_COLS + col.
  function automatic logic [3:0] key_index(input logic [1:0] row, input logic [1:0] col);
    key_index = 4'(int'(row) * NUM_COLS + int'(col));
  endfunction

endpackage

// File: rtl/keypad_scanner_row_sync.sv
// Two-flop synchronizer for the asynchronous, pulled-up matrix row returns.
module row_sync
  import keypad_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_ROWS-1:0] d,
  output logic [NUM_ROWS-1:0] q
);

  logic [NUM_ROWS-1:0] meta_r;

  // Two-stage capture; idles at all-ones (no key pressed) out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_r <= {NUM_ROWS{1'b1}};
      q      <= {NUM_ROWS{1'b1}};
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: column strobing, row sync, frame debounce and
// single-key decode feeding a 16-to-4 priority encoder.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 4,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int DIV_W          = $clog2(SCAN_DIV)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_ROWS-1:0] row_in_n,
  output logic [NUM_COLS-1:0] col_drive_n,
  output logic [KEY_W-1:0]    key_onehot,
  output logic                key_valid,
  output logic                key_press,
  output logic                multi_key
);

  localparam int                 CNT_W      = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0]   DWELL_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]   STABLE_MAX = CNT_W'(DEBOUNCE_SCANS);

  state_t              state_r;
  state_t              state_s;
  logic [1:0]          col_r;
  logic [DIV_W-1:0]    dwell_r;
  logic                dwell_done_s;
  logic [NUM_COLS-1:0] drive_s;
  logic [NUM_ROWS-1:0] row_sync_s;
  logic [KEY_W-1:0]    snapshot_r;
  logic [KEY_W-1:0]    prev_r;
  logic [CNT_W-1:0]    stable_r;
  logic [CNT_W-1:0]    stable_next_s;
  logic                commit_s;
  logic [4:0]          ones_s;

  row_sync u_row_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (row_in_n),
    .q     (row_sync_s)
  );

  assign dwell_done_s = (state_r == S_DRIVE) && (dwell_r == DWELL_LAST);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= S_DRIVE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state: walk the four columns, then one evaluation cycle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_DRIVE: begin
        if (dwell_done_s && (col_r == 2'd3)) begin
          state_s = S_EVAL;
        end else begin
          state_s = S_DRIVE;
        end
      end
      S_EVAL:  state_s = S_DRIVE;
      default: state_s = S_DRIVE;
    endcase
  end

  // FSM output decode: one-cold column strobe while driving, idle during evaluation.
  always_comb begin
    drive_s = 4'b1111;
    case (state_r)
      S_DRIVE: drive_s = ~(4'b0001 << col_r);
      S_EVAL:  drive_s = 4'b1111;
      default: drive_s = 4'b1111;
    endcase
  end

  // Registered column strobe so the pins never glitch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_drive_n <= 4'b1111;
    end else begin
      col_drive_n <= drive_s;
    end
  end

  // Dwell counter and column pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_r   <= 2'd0;
      dwell_r <= '0;
    end else if (state_r == S_DRIVE) begin
      if (dwell_done_s) begin
        dwell_r <= '0;
        col_r   <= col_r + 2'd1;
      end else begin
        dwell_r <= dwell_r + DIV_W'(1);
      end
    end else begin
      dwell_r <= '0;
      col_r   <= 2'd0;
    end
  end

  // Capture the settled, synchronized rows of the active column at the end of its dwell.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snapshot_r <= '0;
    end else if (dwell_done_s) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        snapshot_r[key_index(2'(r), col_r)] <= ~row_sync_s[r];
      end
    end
  end

  // Debounce arithmetic: restart on any frame change, otherwise saturate at the target.
  always_comb begin
    stable_next_s = stable_r;
    if (snapshot_r != prev_r) begin
      stable_next_s = CNT_W'(1);
    end else if (stable_r == STABLE_MAX) begin
      stable_next_s = STABLE_MAX;
    end else begin
      stable_next_s = stable_r + CNT_W'(1);
    end
    commit_s = (state_r == S_EVAL) && (stable_next_s == STABLE_MAX);
  end

  // Number of keys down in the current snapshot.
  always_comb begin
    ones_s = 5'd0;
    for (int i = 0; i < KEY_W; i++) begin
      ones_s = ones_s + 5'(snapshot_r[i]);
    end
  end

  // Debounce state, advanced once per frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stable_r <= '0;
      prev_r   <= '0;
    end else if (state_r == S_EVAL) begin
      stable_r <= stable_next_s;
      prev_r   <= snapshot_r;
    end
  end

  // Committed outputs: single key passes through, multiple keys are rejected.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_onehot <= '0;
      key_valid  <= 1'b0;
      key_press  <= 1'b0;
      multi_key  <= 1'b0;
    end else begin
      key_press <= 1'b0;
      if (commit_s) begin
        if (ones_s == 5'd1) begin
          key_onehot <= snapshot_r;
          key_valid  <= 1'b1;
          multi_key  <= 1'b0;
          key_press  <= (snapshot_r != key_onehot);
        end else if (ones_s == 5'd0) begin
          key_onehot <= '0;
          key_valid  <= 1'b0;
          multi_key  <= 1'b0;
        end else begin
          key_onehot <= '0;
          key_valid  <= 1'b0;
          multi_key  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: matrix model, press scoreboard, scenario tasks.
module tb_keypad_scanner;

  localparam int FRAME = 17;

  typedef struct {
    logic [15:0] onehot;
    logic [3:0]  code;
  } press_t;

  logic        clk;
  logic        rst_n;
  logic [3:0]  row_in_n;
  logic [3:0]  col_drive_n;
  logic [15:0] key_onehot;
  logic        key_valid;
  logic        key_press;
  logic        multi_key;

  logic [15:0] keys;
  logic        mon_en;
  int          n_checks;
  int          n_pass;
  int          pulses;
  press_t      exp_q[$];

  keypad_scanner dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .row_in_n    (row_in_n),
    .col_drive_n (col_drive_n),
    .key_onehot  (key_onehot),
    .key_valid   (key_valid),
    .key_press   (key_press),
    .multi_key   (multi_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Passive matrix: a pressed key pulls its row low while its column is strobed.
  always_comb begin
    row_in_n = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && (col_drive_n[c] == 1'b0)) row_in_n[r] = 1'b0;
      end
    end
  end

  // Reference 16-to-4 priority encoder (highest bit wins).
  function automatic logic [3:0] enc(input logic [15:0] v);
    logic [3:0] e;
    e = 4'd0;
    for (int i = 0; i < 16; i++) if (v[i]) e = 4'(i);
    return e;
  endfunction

  // Scoreboard: every key_press pulse must match the oldest expected press.
  always @(negedge clk) begin
    if (mon_en && key_press === 1'b1) begin
      press_t e;
      pulses++;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_press: got key_onehot=%h, required no key_press", key_onehot);
      end else begin
        e = exp_q.pop_front();
        if (key_onehot !== e.onehot || enc(key_onehot) !== e.code) begin
          $display("FAIL press_value: got key_onehot=%h code=%0d, required %h code=%0d",
                   key_onehot, enc(key_onehot), e.onehot, e.code);
        end else begin
          n_pass++;
        end
      end
    end
  end

  task automatic frames(input int n);
    repeat (n * FRAME) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] v, input logic [3:0] code);
    press_t p;
    p.onehot = v;
    p.code   = code;
    exp_q.push_back(p);
  endtask

  task automatic check_out(input string name, input logic [15:0] oh, input logic v, input logic m);
    n_checks++;
    if (key_onehot !== oh || key_valid !== v || multi_key !== m) begin
      $display("FAIL %s: got onehot=%h valid=%b multi=%b, required onehot=%h valid=%b multi=%b",
               name, key_onehot, key_valid, multi_key, oh, v, m);
    end else begin
      n_pass++;
    end
  endtask

  task automatic check_drained(input string name, input int exp_pulses, input int base);
    n_checks++;
    if (exp_q.size() != 0 || (pulses - base) != exp_pulses) begin
      $display("FAIL %s: got %0d pulses with %0d pending, required %0d pulses with 0 pending",
               name, pulses - base, exp_q.size(), exp_pulses);
    end else begin
      n_pass++;
    end
  endtask

  task automatic test_reset();
    keys  = 16'h0000;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_out("reset_outputs", 16'h0000, 1'b0, 1'b0);
    n_checks++;
    if (col_drive_n !== 4'b1111 || key_press !== 1'b0) begin
      $display("FAIL reset_cols: got col_drive_n=%b press=%b, required 1111 0", col_drive_n, key_press);
    end else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (col_drive_n !== 4'b1110) begin
      $display("FAIL first_col: got %b, required 1110", col_drive_n);
    end else n_pass++;
    repeat (3) @(posedge clk); #1;
    n_checks++;
    if (col_drive_n !== 4'b1110) begin
      $display("FAIL col0_dwell: got %b, required 1110", col_drive_n);
    end else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (col_drive_n !== 4'b1101) begin
      $display("FAIL col1_step: got %b, required 1101", col_drive_n);
    end else n_pass++;
    repeat (FRAME - 5) @(posedge clk); #1;
    mon_en = 1'b1;
  endtask

  task automatic test_single_key();
    int base = pulses;
    keys = 16'h0040;
    push(16'h0040, 4'd6);
    frames(2);
    check_out("single_not_yet", 16'h0000, 1'b0, 1'b0);
    frames(1);
    check_out("single_commit", 16'h0040, 1'b1, 1'b0);
    frames(3);
    check_out("single_held", 16'h0040, 1'b1, 1'b0);
    check_drained("single_pulses", 1, base);
  endtask

  task automatic test_bounce();
    int base;
    keys = 16'h0000;
    frames(3);
    check_out("release_before_bounce", 16'h0000, 1'b0, 1'b0);
    base = pulses;
    for (int f = 0; f < 6; f++) begin
      keys = (f % 2 == 0) ? 16'h0040 : 16'h0000;
      frames(1);
      check_out("bounce_frame", 16'h0000, 1'b0, 1'b0);
    end
    keys = 16'h0000;
    frames(3);
    check_drained("bounce_pulses", 0, base);
  endtask

  task automatic test_multi_key();
    int base = pulses;
    keys = 16'h4004;
    frames(3);
    check_out("multi_commit", 16'h0000, 1'b0, 1'b1);
    keys = 16'h0004;
    push(16'h0004, 4'd2);
    frames(3);
    check_out("multi_release_row3", 16'h0004, 1'b1, 1'b0);
    frames(1);
    check_drained("multi_pulses", 1, base);
  endtask

  task automatic test_change_release();
    int base = pulses;
    keys = 16'h0040;
    push(16'h0040, 4'd6);
    frames(3);
    check_out("change_start", 16'h0040, 1'b1, 1'b0);
    keys = 16'h4000;
    push(16'h4000, 4'd14);
    frames(3);
    check_out("change_to_b", 16'h4000, 1'b1, 1'b0);
    keys = 16'h0000;
    frames(3);
    check_out("release_all", 16'h0000, 1'b0, 1'b0);
    frames(1);
    check_drained("change_pulses", 2, base);
  endtask

  task automatic test_reset_mid_press();
    int base = pulses;
    keys = 16'h0040;
    frames(1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_out("midreset_clear", 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    push(16'h0040, 4'd6);
    frames(2);
    check_out("midreset_2_frames", 16'h0000, 1'b0, 1'b0);
    frames(1);
    check_out("midreset_commit", 16'h0040, 1'b1, 1'b0);
    frames(1);
    check_drained("midreset_pulses", 1, base);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    pulses   = 0;
    mon_en   = 1'b0;
    keys     = 16'h0000;
    rst_n    = 1'b0;
    test_reset();
    test_single_key();
    test_bounce();
    test_multi_key();
    test_change_release();
    test_reset_mid_press();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
